hex_display_sequencer: RTL and testbench
========================================

# hex_display_sequencer

Shares the six on-board seven-segment digits between up to four 24-bit display sources ("pages"), such as the LED register, bus address and switch value. A page is selected either by a debounced push-button or by a timed auto-rotation. The block outputs six registered nibbles plus per-digit blank flags, which feed the existing per-digit seven-segment decoders in the board top. It sits between `mipsfpga_sys` outputs and the HEX decoders.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable synchronized samples needed to accept a key level (20 ms at 50 MHz); minimum 2.
- `ROTATE_CYCLES`, default 100000000: auto-rotation period in cycles (2 s); minimum 2.
- `LZ_BLANK`, default 1: 1 enables leading-zero blanking, 0 disables it.
- `SI_ClkIn` in 1: the single clock; all state is on the rising edge.
- `SI_Reset_N` in 1: synchronous, active-low reset.
- `page0`, `page1`, `page2`, `page3` in 24 each: nibble [4k+3:4k] drives digit k.
- `page_valid` in 4: bit n set means pageN may be shown.
- `key_next` in 1: raw asynchronous request to advance, active-high (board drives `~KEY[n]`).
- `auto_mode` in 1: level; enables timed rotation.
- `hold` in 1: level; freezes the display and page selection.
- `digits` out 24: registered nibbles of the shown page, digit k at [4k+3:4k].
- `blank` out 6: bit k set means digit k should be dark.
- `page_sel` out 2: index of the current page.
- `page_change` out 1: one-cycle pulse on the edge where `page_sel` changes.

## Operation
- **Key path:**
  - 2-flop synchronizer produces `s`.
  - Debounce counter `cnt` increments while `s != deb` and clears when `s == deb`.
  - At `cnt == DEBOUNCE_CYCLES-1` with `s != deb`: `deb <= s`, `cnt <= 0`.
  - A rising edge of `deb` raises a manual advance request, registered for one cycle.
- **Auto path:**
  - Rotation counter `rcnt` counts only when `auto_mode`=1, `hold`=0 and at least 2 pages are valid. Otherwise it is cleared to 0.
  - At `rcnt == ROTATE_CYCLES-1`: raise an auto advance request, `rcnt <= 0`.
  - A manual advance also clears `rcnt`.
- **FSM states:**
  - EMPTY: `page_valid`==0. Go to SHOW when any bit is set; `page_sel` <= lowest valid index, with a `page_change` pulse if the index differs.
  - SHOW: normal operation.
    - On an advance request, `page_sel` <= next valid index after the current one, searching cyclically.
    - If no other page is valid, `page_sel` is unchanged and there is no pulse.
    - If the current page's valid bit drops, force `page_sel` <= next valid index cyclically from the current one, with a pulse. Go to EMPTY if none remain.
    - `hold`=1 goes to HOLD.
  - HOLD: `digits`, `blank` and `page_sel` are frozen. Manual requests are dropped, `rcnt` stays at 0, and valid-bit drops are ignored. `hold`=0 returns to SHOW (or EMPTY if `page_valid`==0), and the invalid-page check is applied on the first SHOW cycle.
- **Simultaneous manual and auto requests:** exactly one advance; `rcnt` cleared.
- **Display register**, updated every cycle except in HOLD:
  - `digits` <= contents of the page at `page_sel`.
  - In EMPTY: `digits` <= 0 and `blank` <= 6'b111111.
  - Otherwise, with `LZ_BLANK`=1, digit k (k=5..1) is blanked when it and all higher digits are zero. Digit 0 is never blanked.
  - With `LZ_BLANK`=0, `blank` is 0.
- **Reset values:** `page_sel`=0, `page_change`=0, `digits`=0, `blank`=6'b111111, FSM=EMPTY, `deb`=0, `cnt`=0, `rcnt`=0, synchronizer=0.

## Timing
- **Key latency:** key first sampled high at edge k gives `deb` high at edge k+1+DEBOUNCE_CYCLES, and `page_sel`/`page_change` at edge k+2+DEBOUNCE_CYCLES.
- **Glitches:** a pulse shorter than DEBOUNCE_CYCLES synchronized samples causes no advance.
- **Auto period:** `page_sel` advances every ROTATE_CYCLES cycles while enabled. The first advance comes ROTATE_CYCLES cycles after enabling.
- **Display latency:** `digits`/`blank` reflect the new `page_sel` one edge after the `page_sel` update. A page input change also appears one edge later.
- **Mid-operation reset:** reset asserted mid-debounce or mid-rotation clears all counters. No advance is issued on release, even with the key held, because `deb` must first be re-qualified; the resulting rise then produces one advance.

## Test plan
- **Reset and idle:** reset, `page_valid`=0 → `blank`=6'h3F, `digits`=0, `page_sel`=0. Then `page_valid`=4'b0001 and `page0`=24'h00_0A_5F → after 2 edges `digits`=24'h000A5F, `blank`=6'b111000.
- **Manual key:** DEBOUNCE_CYCLES=4, valid=4'b1011, key held high → `page_sel` 0→1 at sampling edge + 6, single `page_change` pulse. A second press gives 1→3, and a third gives 3→0. A 3-cycle key glitch gives no change.
- **Auto rotation:** ROTATE_CYCLES=5, valid=4'b0110, `auto_mode`=1 → `page_sel` alternates 1,2,1 every 5 cycles. A manual advance on the same edge as an auto request → one step only, and the next auto step comes 5 cycles later.
- **Invalidation:** showing page 2 with valid=4'b0101, drop bit 2 → `page_sel`=0 with a pulse on the next edge. Then valid=0 → `blank`=6'h3F.
- **Hold:** `hold`=1 while auto-rotating with `page0` changing → `digits` and `page_sel` frozen for 20 cycles, key presses ignored. On release, rotation resumes after a full ROTATE_CYCLES.
- **Reset mid-operation:** reset mid-debounce with the key held → no advance at release; a new advance comes DEBOUNCE_CYCLES+2 cycles after reset release.

Source files
------------

// File: rtl/hex_display_sequencer.sv
// Page sequencer for the six on-board seven-segment digits: selects one of four
// 24-bit sources by debounced key or timed rotation and registers the digits.
module hex_display_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ROTATE_CYCLES   = 100000000,
    parameter bit          LZ_BLANK        = 1'b1
) (
    input  logic        SI_ClkIn,
    input  logic        SI_Reset_N,
    input  logic [23:0] page0,
    input  logic [23:0] page1,
    input  logic [23:0] page2,
    input  logic [23:0] page3,
    input  logic [3:0]  page_valid,
    input  logic        key_next,
    input  logic        auto_mode,
    input  logic        hold,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic [1:0]  page_sel,
    output logic        page_change
);

    // state | meaning
    // EMPTY | no valid page, display dark
    // SHOW  | showing page_sel, advancing on requests
    // HOLD  | display and selection frozen
    typedef enum logic [1:0] {ST_EMPTY, ST_SHOW, ST_HOLD} state_t;

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RW = (ROTATE_CYCLES > 2) ? $clog2(ROTATE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] ROT_MAX = RW'(ROTATE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          man_req_q, man_req_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          auto_req_q, auto_req_d;
    logic [1:0]    page_sel_q, page_sel_d;
    logic          page_change_q, page_change_d;
    logic [23:0]   digits_q, digits_d;
    logic [5:0]    blank_q, blank_d;

    logic          rot_en, rot_tc, adv_req;
    logic [2:0]    nv;
    logic [1:0]    lowest;
    logic [23:0]   shown;
    logic [5:0]    lz_mask;
    logic          all_zero;

    // {found, index} of the nearest valid page after cur, searching cyclically
    function automatic logic [2:0] next_valid(input logic [3:0] v, input logic [1:0] cur);
        logic [1:0] idx;
        next_valid = 3'b000;
        for (int i = 3; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (v[idx]) next_valid = {1'b1, idx};
        end
    endfunction

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == DEB_MAX) deb_d = sync_q[1];
            else                  cnt_d = cnt_q + DW'(1);
        end
        man_req_d = deb_d & ~deb_q;
    end

    assign rot_en     = auto_mode & ~hold & ($countones(page_valid) >= 2);
    assign rot_tc     = (rcnt_q == ROT_MAX);
    assign auto_req_d = rot_en & rot_tc;
    // A manual rise restarts the rotation period so the next auto step is a full period away
    assign rcnt_d     = (!rot_en || rot_tc || man_req_d) ? '0 : rcnt_q + RW'(1);
    assign adv_req    = man_req_q | auto_req_q;

    always_comb begin
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (page_valid[i]) lowest = 2'(i);
        end
    end

    assign nv = next_valid(page_valid, page_sel_q);

    always_comb begin
        state_d    = state_q;
        page_sel_d = page_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (|page_valid) begin
                    state_d    = ST_SHOW;
                    page_sel_d = lowest;
                end
            end
            ST_SHOW: begin
                if (hold) begin
                    state_d = ST_HOLD;
                end else if (!page_valid[page_sel_q]) begin
                    if (nv[2]) page_sel_d = nv[1:0];
                    else       state_d    = ST_EMPTY;
                end else if (adv_req && nv[2]) begin
                    page_sel_d = nv[1:0];
                end
            end
            ST_HOLD: begin
                if (!hold) state_d = (|page_valid) ? ST_SHOW : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        page_change_d = (page_sel_d != page_sel_q);
    end

    always_comb begin
        case (page_sel_q)
            2'd0:    shown = page0;
            2'd1:    shown = page1;
            2'd2:    shown = page2;
            default: shown = page3;
        endcase
    end

    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int k = 5; k >= 1; k--) begin
            all_zero   = all_zero & (shown[4*k +: 4] == 4'd0);
            lz_mask[k] = all_zero;
        end
    end

    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        if (state_q == ST_EMPTY) begin
            digits_d = '0;
            blank_d  = 6'b111111;
        end else if (state_q == ST_SHOW) begin
            digits_d = shown;
            blank_d  = LZ_BLANK ? lz_mask : 6'b000000;
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            state_q       <= ST_EMPTY;
            sync_q        <= '0;
            deb_q         <= 1'b0;
            cnt_q         <= '0;
            man_req_q     <= 1'b0;
            rcnt_q        <= '0;
            auto_req_q    <= 1'b0;
            page_sel_q    <= '0;
            page_change_q <= 1'b0;
            digits_q      <= '0;
            blank_q       <= 6'b111111;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[0], key_next};
            deb_q         <= deb_d;
            cnt_q         <= cnt_d;
            man_req_q     <= man_req_d;
            rcnt_q        <= rcnt_d;
            auto_req_q    <= auto_req_d;
            page_sel_q    <= page_sel_d;
            page_change_q <= page_change_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign page_sel    = page_sel_q;
    assign page_change = page_change_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_hex_display_sequencer;

    localparam int D  = 4;
    localparam int R  = 5;
    localparam bit LZ = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] p0, p1, p2, p3;
    logic [3:0]  valid;
    logic        key, auto_m, hold_m;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic [1:0]  sel;
    logic        chg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_display_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .ROTATE_CYCLES  (R),
        .LZ_BLANK       (LZ)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .page0      (p0),
        .page1      (p1),
        .page2      (p2),
        .page3      (p3),
        .page_valid (valid),
        .key_next   (key),
        .auto_mode  (auto_m),
        .hold       (hold_m),
        .digits     (digits),
        .blank      (blank),
        .page_sel   (sel),
        .page_change(chg)
    );

    localparam int M_EMPTY = 0, M_SHOW = 1, M_HOLD = 2;

    bit          model_live = 1'b0;
    int          ms1 = 0, ms2 = 0, mdeb = 0, mcnt = 0, mman = 0, mauto = 0, mrcnt = 0;
    int          mmode = M_EMPTY, msel = 0, mchg = 0;
    logic [23:0] mdig = '0;
    logic [5:0]  mblank = 6'h3F;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] lz_of(input logic [23:0] v);
        logic [5:0] b;
        b = '0;
        if (LZ) begin
            for (int k = 1; k < 6; k++) if ((v >> (4 * k)) == 24'd0) b[k] = 1'b1;
        end
        return b;
    endfunction

    function automatic int next_from(input logic [3:0] v, input int cur);
        for (int i = 1; i < 4; i++) if (v[(cur + i) % 4]) return (cur + i) % 4;
        return -1;
    endfunction

    function automatic int lowest_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [23:0] page_of(input int i);
        case (i)
            0:       return p0;
            1:       return p1;
            2:       return p2;
            default: return p3;
        endcase
    endfunction

    task automatic model_step();
        int s, ndeb, ncnt, rise, en, nauto, nrcnt, nmode, nsel, nv;
        logic [23:0] ndig;
        logic [5:0]  nbl;
        if (!rst_n) begin
            ms1 = 0; ms2 = 0; mdeb = 0; mcnt = 0; mman = 0; mauto = 0; mrcnt = 0;
            mmode = M_EMPTY; msel = 0; mchg = 0; mdig = '0; mblank = 6'h3F;
            model_live = 1'b1;
            return;
        end
        if (!model_live) return;
        s    = ms2;
        ndeb = mdeb;
        ncnt = 0;
        if (s != mdeb) begin
            if (mcnt == D - 1) ndeb = s;
            else               ncnt = mcnt + 1;
        end
        rise  = (ndeb == 1 && mdeb == 0) ? 1 : 0;
        en    = (auto_m && !hold_m && $countones(valid) >= 2) ? 1 : 0;
        nauto = (en != 0 && mrcnt == R - 1) ? 1 : 0;
        nrcnt = (en != 0 && rise == 0 && mrcnt != R - 1) ? mrcnt + 1 : 0;
        nmode = mmode;
        nsel  = msel;
        case (mmode)
            M_EMPTY: if (valid != 4'd0) begin nmode = M_SHOW; nsel = lowest_of(valid); end
            M_SHOW: begin
                if (hold_m) nmode = M_HOLD;
                else if (!valid[msel]) begin
                    nv = next_from(valid, msel);
                    if (nv < 0) nmode = M_EMPTY;
                    else        nsel  = nv;
                end else if (mman != 0 || mauto != 0) begin
                    nv = next_from(valid, msel);
                    if (nv >= 0) nsel = nv;
                end
            end
            default: if (!hold_m) nmode = (valid != 4'd0) ? M_SHOW : M_EMPTY;
        endcase
        ndig = mdig;
        nbl  = mblank;
        if (mmode == M_EMPTY) begin
            ndig = '0; nbl = 6'h3F;
        end else if (mmode == M_SHOW) begin
            ndig = page_of(msel); nbl = lz_of(ndig);
        end
        mchg = (nsel != msel) ? 1 : 0;
        ms2 = ms1; ms1 = int'(key); mdeb = ndeb; mcnt = ncnt; mman = rise; mauto = nauto;
        mrcnt = nrcnt; mmode = nmode; msel = nsel; mdig = ndig; mblank = nbl;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (model_live) begin
            chk("model_digits", {8'd0, digits}, {8'd0, mdig});
            chk("model_blank", {26'd0, blank}, {26'd0, mblank});
            chk("model_page_sel", {30'd0, sel}, 32'(msel));
            chk("model_page_change", {31'd0, chg}, 32'(mchg));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [23:0] mask;

    initial begin
        rst_n = 1'b0; key = 1'b0; auto_m = 1'b0; hold_m = 1'b0; valid = 4'd0;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
        tick(3);
        chk("reset_digits", {8'd0, digits}, 32'h0);
        chk("reset_blank", {26'd0, blank}, 32'h3F);
        chk("reset_sel", {30'd0, sel}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_blank", {26'd0, blank}, 32'h3F);

        p0 = 24'h000A5F; p1 = 24'h123456; p2 = 24'h00F000; p3 = 24'h000001;
        valid = 4'b0001;
        tick(1);
        chk("first_show_nochg", {31'd0, chg}, 32'd0);
        tick(1);
        chk("first_digits", {8'd0, digits}, 32'h000A5F);
        chk("first_blank", {26'd0, blank}, 32'b111000);

        // manual key: 0 -> 1 -> 3 -> 0
        valid = 4'b1011;
        tick(2);
        key = 1'b1;
        tick(6);
        chk("key_early", {30'd0, sel}, 32'd0);
        tick(1);
        chk("key_sel1", {30'd0, sel}, 32'd1);
        chk("key_pulse", {31'd0, chg}, 32'd1);
        tick(1);
        chk("key_pulse_end", {31'd0, chg}, 32'd0);
        key = 1'b0; tick(8);
        key = 1'b1; tick(7);
        chk("key_sel3", {30'd0, sel}, 32'd3);
        tick(1);
        chk("page3_digits", {8'd0, digits}, 32'h000001);
        chk("page3_blank", {26'd0, blank}, 32'b111110);
        key = 1'b0; tick(8);
        key = 1'b1; tick(7);
        chk("key_wrap0", {30'd0, sel}, 32'd0);
        key = 1'b0; tick(8);
        key = 1'b1; tick(3); key = 1'b0; tick(10);
        chk("glitch_ignored", {30'd0, sel}, 32'd0);

        // auto rotation between pages 1 and 2
        valid = 4'b0110;
        tick(1);
        chk("inval_to1", {30'd0, sel}, 32'd1);
        tick(2);
        auto_m = 1'b1;
        tick(5);
        chk("auto_wait", {30'd0, sel}, 32'd1);
        tick(1);
        chk("auto_step2", {30'd0, sel}, 32'd2);
        chk("auto_pulse", {31'd0, chg}, 32'd1);
        tick(5);
        chk("auto_step1", {30'd0, sel}, 32'd1);
        tick(3);
        key = 1'b1;
        tick(2);
        chk("auto_step2b", {30'd0, sel}, 32'd2);
        tick(5);
        chk("coincident_one_step", {30'd0, sel}, 32'd1);
        tick(4);
        chk("coincident_wait", {30'd0, sel}, 32'd1);
        tick(1);
        chk("after_coincident", {30'd0, sel}, 32'd2);
        auto_m = 1'b0; key = 1'b0;
        tick(8);
        chk("auto_off_sel", {30'd0, sel}, 32'd2);

        // invalidation and empty
        valid = 4'b0101;
        tick(2);
        valid = 4'b0001;
        tick(1);
        chk("drop_to0", {30'd0, sel}, 32'd0);
        chk("drop_pulse", {31'd0, chg}, 32'd1);
        valid = 4'b0000;
        tick(2);
        chk("empty_blank", {26'd0, blank}, 32'h3F);
        chk("empty_digits", {8'd0, digits}, 32'h0);

        // hold freezes everything
        p0 = 24'h0C0FFE;
        valid = 4'b0011;
        tick(2);
        auto_m = 1'b1; hold_m = 1'b1;
        tick(2);
        for (int i = 0; i < 20; i++) begin
            p0  = 24'($urandom);
            key = (i >= 2 && i < 10);
            tick(1);
            chk("hold_digits", {8'd0, digits}, 32'h0C0FFE);
            chk("hold_sel", {30'd0, sel}, 32'd0);
        end
        hold_m = 1'b0;
        tick(5);
        chk("hold_release_wait", {30'd0, sel}, 32'd0);
        tick(1);
        chk("hold_release_step", {30'd0, sel}, 32'd1);

        // reset in the middle of a debounce
        auto_m = 1'b0;
        tick(2);
        key = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        chk("midreset_sel", {30'd0, sel}, 32'd0);
        chk("midreset_blank", {26'd0, blank}, 32'h3F);
        rst_n = 1'b1;
        tick(6);
        chk("midreset_no_adv", {30'd0, sel}, 32'd0);
        tick(1);
        chk("midreset_adv", {30'd0, sel}, 32'd1);
        chk("midreset_pulse", {31'd0, chg}, 32'd1);
        key = 1'b0;
        tick(8);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0)  key    = ~key;
            if ($urandom_range(0, 39) == 0) valid  = 4'($urandom);
            if ($urandom_range(0, 49) == 0) auto_m = ~auto_m;
            if ($urandom_range(0, 59) == 0) hold_m = ~hold_m;
            if ($urandom_range(0, 9) == 0) begin
                mask = 24'hFFFFFF >> (4 * $urandom_range(0, 6));
                case ($urandom_range(0, 3))
                    0:       p0 = 24'($urandom) & mask;
                    1:       p1 = 24'($urandom) & mask;
                    2:       p2 = 24'($urandom) & mask;
                    default: p3 = 24'($urandom) & mask;
                endcase
            end
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
